// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared types for the icache/dcache to RAM arbiter.
//   word_t      32-bit bus word
//   ramstate_t  RAM status reported back to the arbiter
//   arb_state_t arbiter grant state
package memory_arbiter_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} arb_state_t;
endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: cache-side, coherence and RAM-side signals of the arbiter.
//   cache side : iren/iaddr/iwait/iload, dren/dwen/daddr/dstore/dwait/dload
//   coherence  : ccwait/ccinv/ccsnoopaddr (driven constant)
//   RAM side   : ramren/ramwen/ramaddr/ramstore/ramload/ramstate
//   status     : memerr (sticky abort flag)
// master = arbiter view, slave = caches + RAM view.
interface memory_arbiter_if
    import memory_arbiter_pkg::*;
;
    logic      iren, iwait;
    word_t     iaddr, iload;
    logic      dren, dwen, dwait;
    word_t     daddr, dstore, dload;
    logic      ccwait, ccinv;
    word_t     ccsnoopaddr;
    logic      ramren, ramwen;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;
    logic      memerr;

    modport master (
        input  iren, iaddr, dren, dwen, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramren, ramwen, ramaddr, ramstore, memerr
    );
    modport slave (
        output iren, iaddr, dren, dwen, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
               ramren, ramwen, ramaddr, ramstore, memerr
    );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported RAM between icache and dcache.
//   clk   system clock, rising edge
//   rst_n asynchronous active-low reset
//   bus   memory_arbiter_if.master (cache handshake, RAM port, memerr)
// dcache wins conflicts unless the previous completion was a dcache access
// and the icache is waiting, in which case the icache goes next.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int TIMEOUT   = 32,
    parameter int MAX_RETRY = 3
) (
    input logic              clk,
    input logic              rst_n,
    memory_arbiter_if.master bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 1);

    arb_state_t    state, next_state;
    logic          last_d, pause, memerr_q;
    logic [TW-1:0] timer;
    logic [RW-1:0] retries;
    logic          grant, is_d, is_i, req, live, access, err, fail, retry, drop;

    always_comb begin
        grant  = state != IDLE;
        is_d   = state == DGRANT;
        is_i   = state == IGRANT;
        req    = is_d ? (bus.dren | bus.dwen) : (is_i & bus.iren);
        // pause is the one-cycle enable gap after an ERROR; ramstate is ignored then
        live   = grant && req && !pause;
        access = live && bus.ramstate == ACCESS;
        err    = live && bus.ramstate == ERROR;
        // the last allowed ERROR aborts immediately, like a timeout
        fail   = grant && req && !access &&
                 (timer == TW'(TIMEOUT - 1) || (err && retries == RW'(MAX_RETRY - 1)));
        retry  = err && !fail;
        drop   = grant && !req;
        next_state = state;
        if (state == IDLE)
            next_state = ((bus.dren | bus.dwen) && !(bus.iren && last_d)) ? DGRANT :
                         bus.iren ? IGRANT : IDLE;
        else if (access || fail || drop)
            next_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state <= next_state;
            if (access) last_d <= is_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer    <= '0;
            retries  <= '0;
            pause    <= 1'b0;
            memerr_q <= 1'b0;
        end else begin
            timer    <= (grant && !access) ? timer + TW'(1) : '0;
            retries  <= grant ? retries + RW'(retry) : '0;
            pause    <= retry;
            memerr_q <= memerr_q | fail;
        end
    end

    assign bus.ramren      = grant && !pause && (is_d ? bus.dren : bus.iren);
    assign bus.ramwen      = is_d && !pause && bus.dwen;
    assign bus.ramaddr     = is_d ? bus.daddr : is_i ? bus.iaddr : '0;
    assign bus.ramstore    = is_d ? bus.dstore : '0;
    assign bus.dwait       = !(is_d && (access || fail));
    assign bus.iwait       = !(is_i && (access || fail));
    assign bus.dload       = (is_d && access) ? bus.ramload : '0;
    assign bus.iload       = (is_i && access) ? bus.ramload : '0;
    assign bus.ccwait      = 1'b0;
    assign bus.ccinv       = 1'b0;
    assign bus.ccsnoopaddr = '0;
    assign bus.memerr      = memerr_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard bench for memory_arbiter with a scripted RAM model.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    logic        clk, rst_n;
    int          checks, errors;
    exp_t        expq[$];
    logic [31:0] ram_mem[16];
    logic [31:0] ref_mem[16];
    int          busy_cfg, err_left, busy_left;
    bit          stuck, prev_en, en, last_ref;

    memory_arbiter_if bus();

    memory_arbiter #(.TIMEOUT(32), .MAX_RETRY(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: a fresh access starts when enables rise; it answers BUSY for
    // busy_cfg cycles (random when negative), then ERROR while err_left, then ACCESS.
    initial begin
        busy_left = 0;
        prev_en = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            en = bus.ramren | bus.ramwen;
            bus.ramload = ram_mem[bus.ramaddr[3:0]];
            if (!en) bus.ramstate = FREE;
            else begin
                if (!prev_en) busy_left = busy_cfg < 0 ? int'($urandom_range(0, 3)) : busy_cfg;
                if (stuck) bus.ramstate = BUSY;
                else if (busy_left > 0) begin
                    bus.ramstate = BUSY;
                    busy_left--;
                end else if (err_left > 0) begin
                    bus.ramstate = ERROR;
                    err_left--;
                end else bus.ramstate = ACCESS;
            end
            prev_en = en;
        end
    end

    always @(negedge clk)
        if (bus.ramwen && bus.ramstate == ACCESS) ram_mem[bus.ramaddr[3:0]] = bus.ramstore;

    // scoreboard monitor: every wait=0 pulse consumes one expected response
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (!bus.iwait || !bus.dwait)) begin
            checks++;
            if (!bus.iwait && !bus.dwait) begin
                errors++;
                $display("FAIL resp_both: iwait=0 and dwait=0 together");
            end else if (expq.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: d=%0b with nothing expected", !bus.dwait);
            end else begin
                e = expq.pop_front();
                if ((!bus.dwait) !== e.is_d ||
                    (e.chk && (e.is_d ? bus.dload : bus.iload) !== e.data)) begin
                    errors++;
                    $display("FAIL resp: got d=%0b data=%h expected d=%0b data=%h",
                             !bus.dwait, e.is_d ? bus.dload : bus.iload, e.is_d, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input bit is_d, input logic [31:0] data, input bit c);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.chk  = c;
        expq.push_back(e);
    endtask

    task automatic exp_i(input int a);
        push(1'b0, ref_mem[a], 1'b1);
    endtask

    task automatic exp_d(input int a, input bit we, input logic [31:0] wd);
        if (we) begin
            ref_mem[a] = wd;
            push(1'b1, '0, 1'b0);
        end else push(1'b1, ref_mem[a], 1'b1);
    endtask

    // lat counts negedges from the issuing cycle up to and including wait=0
    task automatic req_i(input logic [31:0] a, output int lat);
        bus.iaddr = a;
        bus.iren = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.iwait && lat < 100);
        if (bus.iwait) begin
            checks++;
            errors++;
            $display("FAIL i_timeout: iwait still 1 after %0d cycles", lat);
        end
        @(posedge clk);
        #1 bus.iren = 1'b0;
    endtask

    task automatic req_d(input logic [31:0] a, input bit we, input logic [31:0] wd, output int lat);
        bus.daddr = a;
        bus.dstore = wd;
        bus.dren = !we;
        bus.dwen = we;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.dwait && lat < 100);
        if (bus.dwait) begin
            checks++;
            errors++;
            $display("FAIL d_timeout: dwait still 1 after %0d cycles", lat);
        end
        @(posedge clk);
        #1 begin
            bus.dren = 1'b0;
            bus.dwen = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        err_left = 0;
        stuck = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        last_ref = 1'b0;
    endtask

    initial begin
        int li, ld, kind, ia, da;
        bit we;
        logic [31:0] wd;
        checks = 0;
        errors = 0;
        busy_cfg = 0;
        err_left = 0;
        stuck = 1'b0;
        last_ref = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = 32'h1000_0000 + 32'(i * 7);
            ref_mem[i] = ram_mem[i];
        end
        rst_n = 1'b0;
        bus.iren = 1'b0;
        bus.dren = 1'b0;
        bus.dwen = 1'b0;
        bus.iaddr = '0;
        bus.daddr = '0;
        bus.dstore = '0;
        bus.ramload = '0;
        bus.ramstate = FREE;
        #1;
        chk("rst_waits", {30'd0, bus.iwait, bus.dwait}, 32'd3);
        chk("rst_en", {30'd0, bus.ramren, bus.ramwen}, 32'd0);
        chk("rst_addr", bus.ramaddr | bus.ramstore, 32'd0);
        chk("rst_load", bus.iload | bus.dload, 32'd0);
        chk("rst_flags", {29'd0, bus.memerr, bus.ccwait, bus.ccinv}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single icache read, two BUSY then ACCESS
        ram_mem[0] = 32'hDEAD;
        ref_mem[0] = 32'hDEAD;
        busy_cfg = 2;
        push(1'b0, 32'hDEAD, 1'b1);
        req_i(32'h40, li);
        chk("t1_latency", li, 4);
        @(negedge clk);
        chk("t1_iwait_back", {31'd0, bus.iwait}, 32'd1);
        @(posedge clk);
        #1;

        // simultaneous requests with last_d=0: D, bubble, I
        busy_cfg = 0;
        exp_d(5, 1'b0, '0);
        exp_i(6);
        bus.daddr = 32'd5;
        bus.dren = 1'b1;
        bus.iaddr = 32'd6;
        bus.iren = 1'b1;
        @(negedge clk);
        chk("t2_idle_en", {30'd0, bus.ramren, bus.ramwen}, 32'd0);
        @(negedge clk);
        chk("t2_dgrant_addr", bus.ramaddr, 32'd5);
        chk("t2_dgrant_done", {30'd0, bus.dwait, bus.iwait}, 32'd1);
        @(posedge clk);
        #1 bus.dren = 1'b0;
        @(negedge clk);
        chk("t2_bubble", {30'd0, bus.ramren, bus.ramwen}, 32'd0);
        @(negedge clk);
        chk("t2_igrant_addr", bus.ramaddr, 32'd6);
        @(posedge clk);
        #1 bus.iren = 1'b0;

        // held dwen + iren: D, I, D, I with ramwen only in data grants
        exp_d(7, 1'b1, 32'hCAFE_0007);
        exp_i(8);
        exp_d(7, 1'b1, 32'hCAFE_0007);
        exp_i(8);
        bus.daddr = 32'd7;
        bus.dstore = 32'hCAFE_0007;
        bus.dwen = 1'b1;
        bus.iaddr = 32'd8;
        bus.iren = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("t3_en_%0d", k), {30'd0, bus.ramren, bus.ramwen},
                {30'd0, k == 3 || k == 7, k == 1 || k == 5});
        end
        @(posedge clk);
        #1 begin
            bus.dwen = 1'b0;
            bus.iren = 1'b0;
        end
        last_ref = 1'b0;

        // randomized traffic against the transaction-level model
        busy_cfg = -1;
        repeat (60) begin
            kind = $urandom_range(0, 3);
            ia = $urandom_range(0, 15);
            da = $urandom_range(0, 15);
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            if (kind == 0) begin
                exp_i(ia);
                req_i(32'(ia), li);
                last_ref = 1'b0;
            end else if (kind == 1) begin
                exp_d(da, we, wd);
                req_d(32'(da), we, wd, ld);
                last_ref = 1'b1;
            end else begin
                // the dcache request loses only when it won last time
                if (last_ref) begin
                    exp_i(ia);
                    exp_d(da, we, wd);
                end else begin
                    exp_d(da, we, wd);
                    exp_i(ia);
                end
                fork
                    req_i(32'(ia), li);
                    req_d(32'(da), we, wd, ld);
                join
            end
        end

        // two ERRORs then ACCESS completes normally
        busy_cfg = 0;
        err_left = 2;
        exp_d(3, 1'b0, '0);
        req_d(32'd3, 1'b0, '0, ld);
        chk("t5b_latency", ld, 6);
        @(negedge clk);
        chk("t5b_memerr", {31'd0, bus.memerr}, 32'd0);

        // stuck BUSY: abort on the 32nd grant cycle
        do_reset();
        stuck = 1'b1;
        push(1'b1, '0, 1'b1);
        req_d(32'd2, 1'b0, '0, ld);
        chk("t4_latency", ld, 33);
        @(negedge clk);
        chk("t4_memerr", {31'd0, bus.memerr}, 32'd1);
        stuck = 1'b0;

        // three ERRORs exhaust the retries
        do_reset();
        @(negedge clk);
        chk("t5a_memerr_clr", {31'd0, bus.memerr}, 32'd0);
        @(posedge clk);
        #1 err_left = 3;
        push(1'b1, '0, 1'b1);
        req_d(32'd4, 1'b0, '0, ld);
        chk("t5a_latency", ld, 6);
        @(negedge clk);
        chk("t5a_memerr", {31'd0, bus.memerr}, 32'd1);

        // reset while in a data grant
        @(posedge clk);
        #1 begin
            stuck = 1'b1;
            bus.daddr = 32'd9;
            bus.dren = 1'b1;
        end
        repeat (3) @(negedge clk);
        chk("t6_granted", {31'd0, bus.ramren}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_en", {30'd0, bus.ramren, bus.ramwen}, 32'd0);
        chk("t6_rst_wait", {30'd0, bus.iwait, bus.dwait}, 32'd3);
        chk("t6_rst_out", bus.ramaddr | bus.dload, 32'd0);
        chk("t6_rst_memerr", {31'd0, bus.memerr}, 32'd0);
        @(posedge clk);
        #1 begin
            bus.dren = 1'b0;
            stuck = 1'b0;
            rst_n = 1'b1;
        end
        @(negedge clk);
        chk("t6_idle", {30'd0, bus.ramren, bus.ramwen}, 32'd0);

        chk("exp_left", expq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
